// File: rtl/data_mem_responder_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
// Latency/backpressure are defined by the modules that import this package.
package data_mem_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2,
    ST_WAIT  = 2'd3
  } flush_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-responder data-memory port: load/store request, load data, stall and flush handshake.
// master = core side, slave = responder side.
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) ();

  logic                         mem_ren;
  logic                         mem_wen;
  logic [31:0]                  mem_addr;
  logic [DATA_W-1:0]            mem_dout;
  logic [DATA_W-1:0]            mem_din;
  logic                         mem_stall;
  logic                         flush_req;
  logic                         flush_done;
  logic [cnt_width(DEPTH)-1:0]  wbuf_count;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, flush_req,
    input  mem_din, mem_stall, flush_done, wbuf_count
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, flush_req,
    output mem_din, mem_stall, flush_done, wbuf_count
  );

endinterface

// File: rtl/data_mem_responder_mem_wbuf.sv
// Circular store buffer with youngest-match forwarding; push/pop take effect next edge.
// No internal backpressure: caller must not push when full or pop when empty.
module mem_wbuf
  import data_mem_responder_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] look_idx,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  output logic [ADDR_W-1:0] head_idx,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] idx_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  slot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      idx_q[tail]  <= push_idx;
      data_q[tail] <= push_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (idx_q[slot] == look_idx)) begin
        hit      = 1'b1;
        hit_data = data_q[slot];
      end
    end
  end

  assign head_idx  = idx_q[head];
  assign head_data = data_q[head];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: zero-latency loads with store forwarding, stores posted to a buffer drained on load-free cycles.
// Stores stall when the buffer is full or a flush is in progress; loads never stall.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);

  logic [DATA_W-1:0] ram [2**ADDR_W];

  flush_state_t      state;
  logic              flush_done;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  count;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [ADDR_W-1:0] head_idx;
  logic [DATA_W-1:0] head_data;
  logic              stall;
  logic              accept;
  logic              drain;
  logic              unused_addr;

  assign idx         = bus.mem_addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  // A store wins over a simultaneous load; any load occupies the RAM port.
  assign stall  = bus.mem_wen && ((count == CNT_W'(DEPTH)) || (state != ST_RUN));
  assign accept = bus.mem_wen && !stall;
  assign drain  = !bus.mem_ren && (count != '0);

  mem_wbuf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (drain),
    .push_idx  (idx),
    .push_data (bus.mem_dout),
    .look_idx  (idx),
    .hit       (hit),
    .hit_data  (hit_data),
    .head_idx  (head_idx),
    .head_data (head_data),
    .count     (count)
  );

  // Gated by reset so pending stores are dropped rather than written.
  always_ff @(posedge clk) begin
    if (rst && drain) ram[head_idx] <= head_data;
  end

  assign bus.mem_din    = hit ? hit_data : ram[idx];
  assign bus.mem_stall  = stall;
  assign bus.wbuf_count = count;
  assign bus.flush_done = flush_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_RUN:   if (bus.flush_req) state <= ST_FLUSH;
        ST_FLUSH: if (count == '0) begin
                    state      <= ST_DONE;
                    flush_done <= 1'b1;
                  end
        ST_DONE:  state <= bus.flush_req ? ST_WAIT : ST_RUN;
        ST_WAIT:  if (!bus.flush_req) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder against a queue-based reference model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 64;

  // Model modes: normal, draining for a flush, announcing completion, holding until release.
  localparam int M_NORMAL   = 0;
  localparam int M_DRAINING = 1;
  localparam int M_ANNOUNCE = 2;
  localparam int M_HOLD     = 3;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } wentry_t;

  typedef struct {
    bit          chk_din;
    logic [31:0] din;
    bit          stall;
    bit          fdone;
    int          cnt;
  } exp_t;

  logic clk;
  logic rst;
  data_mem_responder_if #(.DEPTH(DEPTH)) bus ();

  data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  exp_t        expq[$];
  exp_t        mon_e;
  wentry_t     wq[$];
  logic [31:0] ram_m [int];
  int          mode = M_NORMAL;

  function automatic logic [31:0] addr_of(input int widx);
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = widx[ADDR_W-1:0];
    return a;
  endfunction

  function automatic logic [31:0] m_load(input int widx);
    logic [31:0] v;
    v = ram_m.exists(widx) ? ram_m[widx] : 32'h0;
    foreach (wq[i]) if (wq[i].idx == widx) v = wq[i].data;
    return v;
  endfunction

  // One core cycle: predict outputs, queue them for the monitor, then advance the model.
  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit f, input bit rs, output bit stalled);
    exp_t    e;
    wentry_t ne;
    int      widx;
    int      n;
    bus.mem_ren   = r;
    bus.mem_wen   = w;
    bus.mem_addr  = a;
    bus.mem_dout  = d;
    bus.flush_req = f;
    rst           = rs;
    widx    = int'(a[ADDR_W+1:2]);
    n       = wq.size();
    e.stall = w && (n == DEPTH || mode != M_NORMAL);
    e.fdone = (mode == M_ANNOUNCE);
    e.cnt   = n;
    e.chk_din = r && !w;
    e.din   = m_load(widx);
    expq.push_back(e);
    stalled = e.stall;
    if (!rs) begin
      wq.delete();
      mode = M_NORMAL;
    end else begin
      if (!r && n > 0) begin
        ram_m[wq[0].idx] = wq[0].data;
        void'(wq.pop_front());
      end
      if (w && !e.stall) begin
        ne.idx  = widx;
        ne.data = d;
        wq.push_back(ne);
      end
      case (mode)
        M_NORMAL:   if (f) mode = M_DRAINING;
        M_DRAINING: if (n == 0) mode = M_ANNOUNCE;
        M_ANNOUNCE: mode = f ? M_HOLD : M_NORMAL;
        default:    if (!f) mode = M_NORMAL;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit f);
    bit st;
    for (int i = 0; i < n; i++) drive(0, 0, addr_of(0), 32'h0, f, 1, st);
  endtask

  task automatic load(input int widx);
    bit st;
    drive(1, 0, addr_of(widx), $urandom, 0, 1, st);
  endtask

  // Retries like a core holding its request; retries free the port so a drain can happen.
  task automatic do_store(input int widx, input logic [31:0] d, input bit r, input bit f);
    bit st;
    int tries;
    tries = 0;
    drive(r, 1, addr_of(widx), d, f, 1, st);
    while (st) begin
      tries++;
      if (tries > 50) begin
        tests++;
        fails++;
        $display("FAIL store_retry idx=%0d got=still stalled after 50 retries expected=accepted", widx);
        break;
      end
      drive(0, 1, addr_of(widx), d, f, 1, st);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      tests++;
      if (bus.mem_stall !== mon_e.stall) begin
        fails++;
        $display("FAIL stall cyc=%0d got=%b expected=%b", cyc, bus.mem_stall, mon_e.stall);
      end
      tests++;
      if (bus.flush_done !== mon_e.fdone) begin
        fails++;
        $display("FAIL flush_done cyc=%0d got=%b expected=%b", cyc, bus.flush_done, mon_e.fdone);
      end
      tests++;
      if (bus.wbuf_count !== 3'(mon_e.cnt) || int'(bus.wbuf_count) > DEPTH) begin
        fails++;
        $display("FAIL wbuf_count cyc=%0d got=%0d expected=%0d", cyc, bus.wbuf_count, mon_e.cnt);
      end
      if (mon_e.chk_din) begin
        tests++;
        if (bus.mem_din !== mon_e.din) begin
          fails++;
          $display("FAIL load_data cyc=%0d addr=%h got=%h expected=%h", cyc, bus.mem_addr, bus.mem_din, mon_e.din);
        end
      end
    end
  end

  initial begin
    bit st;
    bit f;
    int guard;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_dout  = '0;
    bus.flush_req = 1'b0;
    rst           = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, including a store presented while reset is held.
    drive(0, 1, addr_of(5), 32'hDEAD_BEEF, 0, 0, st);
    drive(0, 0, addr_of(0), 32'h0, 0, 0, st);

    // Known contents for every word the bench will ever load.
    for (int i = 0; i < NWORDS; i++) do_store(i, 32'hC0DE_0000 + 32'(i), 0, 0);
    idle(4, 0);

    // Forwarding to a load on the very next cycle.
    do_store(32'h100 >> 2, 32'h1, 0, 0);
    load(32'h100 >> 2);
    idle(3, 0);

    // Youngest of two same-address stores wins, and ends up in RAM.
    do_store(32'h40 >> 2, 32'hA, 1, 0);
    do_store(32'h40 >> 2, 32'hB, 1, 0);
    load(32'h40 >> 2);
    idle(4, 0);
    load(32'h40 >> 2);

    // Fill the buffer while loads hold the port, then a fifth store must stall and retry.
    for (int k = 0; k < 5; k++) do_store(8 + k, 32'hF000_0000 + 32'(k), 1, 0);
    idle(6, 0);
    for (int k = 0; k < 5; k++) load(8 + k);

    // Flush with three pending stores and a store held against it.
    for (int k = 0; k < 3; k++) do_store(30 + k, 32'hA5A5_0000 + 32'(k), 1, 0);
    drive(0, 0, addr_of(0), 32'h0, 1, 1, st);
    for (int k = 0; k < 8; k++) drive(0, 1, addr_of(33), 32'h5555_5555, 1, 1, st);
    idle(3, 1);
    idle(1, 0);
    do_store(33, 32'h5555_5555, 0, 0);
    idle(3, 0);

    // Sustained loads keep the port busy: two entries stay buffered and forward.
    do_store(40, 32'h4040_4040, 1, 0);
    do_store(41, 32'h4141_4141, 1, 0);
    for (int k = 0; k < 10; k++) load((k % 3 == 2) ? $urandom_range(0, NWORDS - 1) : 40 + (k % 3));
    idle(3, 0);

    // Reset with three pending stores discards them.
    for (int k = 0; k < 3; k++) do_store(20 + k, 32'hBAD0_0000 + 32'(k), 1, 0);
    drive(0, 0, addr_of(0), 32'h0, 0, 0, st);
    drive(1, 1, addr_of(50), 32'h5050_5050, 0, 1, st);
    for (int k = 0; k < 3; k++) load(20 + k);
    idle(3, 0);

    // Randomised traffic with occasional flushes and resets.
    f = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) f = !f;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            addr_of($urandom_range(0, NWORDS - 1)), $urandom, f,
            1'($urandom_range(0, 299) != 0), st);
    end

    // Drain everything, then read back the whole working set.
    idle(4, 0);
    guard = 0;
    while (wq.size() > 0 && guard < 20) begin
      idle(1, 0);
      guard++;
    end
    for (int i = 0; i < NWORDS; i++) load(i);

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (expq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
